alu_exec_pipe: RTL and testbench
================================

// Module: alu_exec_pipe
// PURPOSE
//  Parametrised execute stage: operand bypass, 1-cycle ALU/address ops, multi-cycle MUL, BEQ/JUMP resolution.
//  Sits between decode/regfile read and the memory stage.
//  valid/ready input handshake; one registered result slot, frozen by stall_alu.
// PARAMETERS
//  DATA_W    32  operand/result width
//  PC_W      32  program counter width
//  REG_AW    5   register address width; reg 0 never bypassed
//  MUL_LAT   4   MUL accept-to-out_valid latency in cycles; legal 2..16
// PORTS
//  clock            in   1       core clock
//  reset_c          in   1       async active-low reset
//  stall_alu        in   1       downstream stall: hold output slot
//  in_valid         in   1       decode presents an instruction
//  in_ready         out  1       stage accepts this cycle
//  in_opcode        in   8       00 ADD,01 SUB,02 MUL,10 LDB,11 LDW,12 STB,13 STW,30 BEQ,31 JUMP
//  in_pc            in   PC_W    PC of instruction
//  in_imm           in   PC_W    BEQ branch offset (two's complement)
//  in_val1/in_val2  in   DATA_W  regfile operands
//  in_rs1/in_rs2    in   REG_AW  operand source registers
//  in_rd            in   REG_AW  destination register
//  byp_valid        in   1       memory stage holds a writeback value
//  byp_rd           in   REG_AW  its destination register
//  byp_data         in   DATA_W  its data
//  out_valid        out  1       output slot holds a result
//  out_result       out  DATA_W  ALU result / effective address
//  out_rd           out  REG_AW  destination register
//  out_wr_en        out  1       result targets regfile (ADD/SUB/MUL)
//  out_mem_rd       out  1       LDB/LDW
//  out_mem_wr       out  1       STB/STW
//  out_branch_taken out  1       redirect fetch to out_branch_pc
//  out_branch_pc    out  PC_W    branch/jump target
//  out_illegal      out  1       opcode not in table
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, mul counter 0; reset mid-MUL abandons the op, nothing emitted.
//  Bypass (combinational at accept): opN = (byp_valid && byp_rd==in_rsN && in_rsN!=0) ? byp_data : in_valN.
//  slot_free = !out_valid || !stall_alu. Output slot loads only when slot_free.
//  Accept = in_valid && in_ready. in_ready = (state==IDLE) && slot_free.
//  Accepted, !slot_free on next edge impossible: stall is sampled at accept.
//  Slot empties (out_valid=0) on a slot_free cycle with nothing to load.
//  Output fields hold their values while the slot is stalled.
//  Ops:
//   ADD/SUB -> op1+/-op2 mod 2^DATA_W; latency 1.
//   LD*/ST* -> address op1+op2; latency 1.
//   MUL -> low DATA_W bits of op1*op2.
//   BEQ -> taken iff op1==op2; target in_pc+in_imm mod 2^PC_W.
//   JUMP -> taken=1, target op1[PC_W-1:0] (zero-extended if PC_W>DATA_W).
//   Illegal -> out_valid=1, out_illegal=1, all enables 0.
//   Non-branch ops: out_branch_taken=0.
//  FSM IDLE / MUL_BUSY:
//   IDLE: accept MUL -> latch ops and rd, cnt=MUL_LAT-1, go MUL_BUSY; other ops load slot directly.
//   MUL_BUSY: in_ready=0; cnt decrements to 1.
//   At cnt==1 with slot_free -> load slot, go IDLE.
//   At cnt==1 with stall -> stay at cnt==1 until slot_free.
//   MUL operands are captured at accept; later bypass changes are ignored.
//  Simultaneous stall and completion: completion waits; the old slot contents are held unchanged.
// TESTING
//  Reset low mid-MUL at cycle 2 -> all outputs 0; next ADD 3+4 gives out_result=7 one cycle after accept.
//  ADD 0xFFFFFFFF+1 -> out_result=0, out_wr_en=1; SUB 0-1 -> 0xFFFFFFFF.
//  MUL 7*6, MUL_LAT=4, stall_alu high cycles 3-5 -> in_ready=0 throughout; out_result=42 valid once stall drops; single result.
//  ADD rs1=5, in_val1=1, byp_valid=1, byp_rd=5, byp_data=10, val2=2 -> 12; same with rs=0 -> 3.
//  BEQ pc=0x100, imm=0xFFFFFFF0, equal ops -> out_branch_pc=0xF0, taken=1; unequal -> taken=0.
//  opcode 0x55 -> out_illegal=1, all enables 0; stall_alu=1 for 3 cycles -> outputs frozen, in_ready=0.

Source files
------------

// File: rtl/alu_exec_pipe.sv
// Execute stage: operand bypass, single-cycle ALU/address/branch ops and a multi-cycle MUL
// feeding one registered output slot that downstream can hold with stall_alu.
module alu_exec_pipe #(
  parameter int DATA_W  = 32,
  parameter int PC_W    = 32,
  parameter int REG_AW  = 5,
  parameter int MUL_LAT = 4   // legal range 2..16
) (
  input  logic              clock,
  input  logic              reset_c,
  input  logic              stall_alu,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_opcode,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [PC_W-1:0]   in_imm,
  input  logic [DATA_W-1:0] in_val1,
  input  logic [DATA_W-1:0] in_val2,
  input  logic [REG_AW-1:0] in_rs1,
  input  logic [REG_AW-1:0] in_rs2,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              byp_valid,
  input  logic [REG_AW-1:0] byp_rd,
  input  logic [DATA_W-1:0] byp_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_result,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_wr_en,
  output logic              out_mem_rd,
  output logic              out_mem_wr,
  output logic              out_branch_taken,
  output logic [PC_W-1:0]   out_branch_pc,
  output logic              out_illegal
);

  localparam logic [7:0] OP_ADD  = 8'h00;
  localparam logic [7:0] OP_SUB  = 8'h01;
  localparam logic [7:0] OP_MUL  = 8'h02;
  localparam logic [7:0] OP_LDB  = 8'h10;
  localparam logic [7:0] OP_LDW  = 8'h11;
  localparam logic [7:0] OP_STB  = 8'h12;
  localparam logic [7:0] OP_STW  = 8'h13;
  localparam logic [7:0] OP_BEQ  = 8'h30;
  localparam logic [7:0] OP_JUMP = 8'h31;
  localparam int         CNT_W   = 5;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_MUL_BUSY = 1'b1} state_t;

  state_t              state_r;
  logic [CNT_W-1:0]    cnt_r;
  logic [DATA_W-1:0]   mul_a_r, mul_b_r;
  logic [REG_AW-1:0]   mul_rd_r;

  logic                out_valid_r, out_wr_en_r, out_mem_rd_r, out_mem_wr_r;
  logic                out_branch_taken_r, out_illegal_r;
  logic [DATA_W-1:0]   out_result_r;
  logic [REG_AW-1:0]   out_rd_r;
  logic [PC_W-1:0]     out_branch_pc_r;

  logic                slot_free_s, in_ready_s, accept_s, is_mul_s;
  logic                mul_done_s, load_direct_s;
  logic [DATA_W-1:0]   op1_s, op2_s, mul_lo_s;
  logic [DATA_W-1:0]   dec_result_s;
  logic [REG_AW-1:0]   dec_rd_s;
  logic                dec_wr_s, dec_mrd_s, dec_mwr_s, dec_tk_s, dec_ill_s;
  logic [PC_W-1:0]     dec_bpc_s;

  // Register 0 is hard-wired, so it must never pick up a forwarded value.
  assign op1_s = (byp_valid && (byp_rd == in_rs1) && (in_rs1 != '0)) ? byp_data : in_val1;
  assign op2_s = (byp_valid && (byp_rd == in_rs2) && (in_rs2 != '0)) ? byp_data : in_val2;

  assign slot_free_s   = !out_valid_r || !stall_alu;
  assign in_ready_s    = (state_r == ST_IDLE) && slot_free_s;
  assign accept_s      = in_valid && in_ready_s;
  assign is_mul_s      = (in_opcode == OP_MUL);
  assign load_direct_s = accept_s && !is_mul_s;
  assign mul_done_s    = (state_r == ST_MUL_BUSY) && (cnt_r == CNT_W'(1)) && slot_free_s;
  assign mul_lo_s      = mul_a_r * mul_b_r;

  // Decode single-cycle ops into the values the output slot would load this cycle.
  always_comb begin
    dec_result_s = '0;
    dec_rd_s     = in_rd;
    dec_wr_s     = 1'b0;
    dec_mrd_s    = 1'b0;
    dec_mwr_s    = 1'b0;
    dec_tk_s     = 1'b0;
    dec_bpc_s    = '0;
    dec_ill_s    = 1'b0;
    case (in_opcode)
      OP_ADD: begin
        dec_result_s = op1_s + op2_s;
        dec_wr_s     = 1'b1;
      end
      OP_SUB: begin
        dec_result_s = op1_s - op2_s;
        dec_wr_s     = 1'b1;
      end
      OP_MUL: begin
        dec_wr_s = 1'b1;
      end
      OP_LDB, OP_LDW: begin
        dec_result_s = op1_s + op2_s;
        dec_mrd_s    = 1'b1;
      end
      OP_STB, OP_STW: begin
        dec_result_s = op1_s + op2_s;
        dec_mwr_s    = 1'b1;
      end
      OP_BEQ: begin
        dec_tk_s  = (op1_s == op2_s);
        dec_bpc_s = in_pc + in_imm;
      end
      OP_JUMP: begin
        dec_tk_s  = 1'b1;
        dec_bpc_s = PC_W'(op1_s);
      end
      default: begin
        dec_ill_s = 1'b1;
        dec_rd_s  = '0;
      end
    endcase
  end

  // Sequencer: IDLE accepts work, MUL_BUSY counts down the multiply latency.
  always_ff @(posedge clock or negedge reset_c) begin
    if (!reset_c) begin
      state_r  <= ST_IDLE;
      cnt_r    <= '0;
      mul_a_r  <= '0;
      mul_b_r  <= '0;
      mul_rd_r <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s && is_mul_s) begin
            mul_a_r  <= op1_s;
            mul_b_r  <= op2_s;
            mul_rd_r <= in_rd;
            cnt_r    <= CNT_W'(MUL_LAT - 1);
            state_r  <= ST_MUL_BUSY;
          end
        end
        ST_MUL_BUSY: begin
          // Parked at 1 until the slot can take the product.
          if (cnt_r == CNT_W'(1)) begin
            if (slot_free_s) begin
              cnt_r   <= '0;
              state_r <= ST_IDLE;
            end
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= '0;
        end
      endcase
    end
  end

  // Output slot: loads a MUL completion or a direct op, empties when drained, else holds.
  always_ff @(posedge clock or negedge reset_c) begin
    if (!reset_c) begin
      out_valid_r        <= 1'b0;
      out_result_r       <= '0;
      out_rd_r           <= '0;
      out_wr_en_r        <= 1'b0;
      out_mem_rd_r       <= 1'b0;
      out_mem_wr_r       <= 1'b0;
      out_branch_taken_r <= 1'b0;
      out_branch_pc_r    <= '0;
      out_illegal_r      <= 1'b0;
    end else if (mul_done_s) begin
      out_valid_r        <= 1'b1;
      out_result_r       <= mul_lo_s;
      out_rd_r           <= mul_rd_r;
      out_wr_en_r        <= 1'b1;
      out_mem_rd_r       <= 1'b0;
      out_mem_wr_r       <= 1'b0;
      out_branch_taken_r <= 1'b0;
      out_branch_pc_r    <= '0;
      out_illegal_r      <= 1'b0;
    end else if (load_direct_s) begin
      out_valid_r        <= 1'b1;
      out_result_r       <= dec_result_s;
      out_rd_r           <= dec_rd_s;
      out_wr_en_r        <= dec_wr_s;
      out_mem_rd_r       <= dec_mrd_s;
      out_mem_wr_r       <= dec_mwr_s;
      out_branch_taken_r <= dec_tk_s;
      out_branch_pc_r    <= dec_bpc_s;
      out_illegal_r      <= dec_ill_s;
    end else if (slot_free_s) begin
      // Drop the side-effect flags with valid so a stale slot can never fire.
      out_valid_r        <= 1'b0;
      out_wr_en_r        <= 1'b0;
      out_mem_rd_r       <= 1'b0;
      out_mem_wr_r       <= 1'b0;
      out_branch_taken_r <= 1'b0;
      out_illegal_r      <= 1'b0;
    end
  end

  assign in_ready         = in_ready_s;
  assign out_valid        = out_valid_r;
  assign out_result       = out_result_r;
  assign out_rd           = out_rd_r;
  assign out_wr_en        = out_wr_en_r;
  assign out_mem_rd       = out_mem_rd_r;
  assign out_mem_wr       = out_mem_wr_r;
  assign out_branch_taken = out_branch_taken_r;
  assign out_branch_pc    = out_branch_pc_r;
  assign out_illegal      = out_illegal_r;

endmodule

// File: tb/tb_alu_exec_pipe.sv
// Table-driven bench for alu_exec_pipe with an in-order expected-result scoreboard,
// plus hand sequences for MUL latency/stall, illegal-op stall and reset during MUL.
module tb_alu_exec_pipe;

  logic        clock = 1'b0;
  logic        reset_c = 1'b0;
  logic        stall_alu = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_opcode = 8'h00;
  logic [31:0] in_pc = 32'h0, in_imm = 32'h0, in_val1 = 32'h0, in_val2 = 32'h0;
  logic [4:0]  in_rs1 = 5'd0, in_rs2 = 5'd0, in_rd = 5'd0;
  logic        byp_valid = 1'b0;
  logic [4:0]  byp_rd = 5'd0;
  logic [31:0] byp_data = 32'h0;
  logic        out_valid, out_wr_en, out_mem_rd, out_mem_wr, out_branch_taken, out_illegal;
  logic [31:0] out_result, out_branch_pc;
  logic [4:0]  out_rd;

  alu_exec_pipe #(.DATA_W(32), .PC_W(32), .REG_AW(5), .MUL_LAT(4)) dut (
    .clock(clock), .reset_c(reset_c), .stall_alu(stall_alu),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_pc(in_pc), .in_imm(in_imm), .in_val1(in_val1), .in_val2(in_val2),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .byp_valid(byp_valid), .byp_rd(byp_rd), .byp_data(byp_data),
    .out_valid(out_valid), .out_result(out_result), .out_rd(out_rd),
    .out_wr_en(out_wr_en), .out_mem_rd(out_mem_rd), .out_mem_wr(out_mem_wr),
    .out_branch_taken(out_branch_taken), .out_branch_pc(out_branch_pc),
    .out_illegal(out_illegal)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          id;
    bit          chk_res;
    logic [31:0] res;
    bit          chk_rd;
    logic [4:0]  rd;
    bit          wr, mrd, mwr, tk;
    bit          chk_bpc;
    logic [31:0] bpc;
    bit          ill;
  } exp_t;

  typedef struct {
    logic [7:0]  op;
    logic [31:0] pc, imm, v1, v2;
    logic [4:0]  rs1, rs2, rd;
    bit          bv;
    logic [4:0]  brd;
    logic [31:0] bdata;
    exp_t        e;
  } vec_t;

  exp_t cur_exp;
  exp_t exp_q[$];
  exp_t mon_e;
  bit   mon_bad;
  int   n_vec = 0;
  int   n_err = 0;
  vec_t tbl[15];
  vec_t v;

  function automatic exp_t mke(int id, bit cr, logic [31:0] r, bit crd, logic [4:0] rd,
                               bit wr, bit mrd, bit mwr, bit tk, bit cb, logic [31:0] bpc, bit ill);
    exp_t e;
    e.id = id; e.chk_res = cr; e.res = r; e.chk_rd = crd; e.rd = rd;
    e.wr = wr; e.mrd = mrd; e.mwr = mwr; e.tk = tk;
    e.chk_bpc = cb; e.bpc = bpc; e.ill = ill;
    return e;
  endfunction

  function automatic vec_t mkv(logic [7:0] op, logic [31:0] pc, logic [31:0] imm,
                               logic [31:0] v1, logic [31:0] v2, logic [4:0] rs1, logic [4:0] rs2,
                               logic [4:0] rd, bit bv, logic [4:0] brd, logic [31:0] bdata, exp_t e);
    vec_t x;
    x.op = op; x.pc = pc; x.imm = imm; x.v1 = v1; x.v2 = v2;
    x.rs1 = rs1; x.rs2 = rs2; x.rd = rd; x.bv = bv; x.brd = brd; x.bdata = bdata; x.e = e;
    return x;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Present one instruction and hold it until the stage accepts it (bounded).
  task automatic issue(input vec_t x);
    bit ok;
    ok = 1'b0;
    in_opcode = x.op; in_pc = x.pc; in_imm = x.imm; in_val1 = x.v1; in_val2 = x.v2;
    in_rs1 = x.rs1; in_rs2 = x.rs2; in_rd = x.rd;
    byp_valid = x.bv; byp_rd = x.brd; byp_data = x.bdata;
    cur_exp = x.e;
    in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL issue_timeout: vec %0d never accepted", x.e.id);
    end
    @(posedge clock);
    #1 in_valid = 1'b0;
  endtask

  // Scoreboard: a result is consumed when valid and not stalled; accepts push expectations.
  always @(negedge clock) begin
    if (reset_c) begin
      if (out_valid && !stall_alu) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_out: got res=%h rd=%0d, want no output", out_result, out_rd);
        end else begin
          mon_e = exp_q.pop_front();
          mon_bad = (mon_e.chk_res && (out_result !== mon_e.res)) ||
                    (mon_e.chk_rd && (out_rd !== mon_e.rd)) ||
                    (out_wr_en !== mon_e.wr) || (out_mem_rd !== mon_e.mrd) ||
                    (out_mem_wr !== mon_e.mwr) || (out_branch_taken !== mon_e.tk) ||
                    (mon_e.chk_bpc && (out_branch_pc !== mon_e.bpc)) ||
                    (out_illegal !== mon_e.ill);
          if (mon_bad) begin
            n_err++;
            $display("FAIL vec%0d: got res=%h rd=%0d wr/rd/wr/tk/ill=%b%b%b%b%b bpc=%h, want res=%h rd=%0d wr/rd/wr/tk/ill=%b%b%b%b%b bpc=%h",
                     mon_e.id, out_result, out_rd, out_wr_en, out_mem_rd, out_mem_wr,
                     out_branch_taken, out_illegal, out_branch_pc, mon_e.res, mon_e.rd,
                     mon_e.wr, mon_e.mrd, mon_e.mwr, mon_e.tk, mon_e.ill, mon_e.bpc);
          end
        end
      end
      if (in_valid && in_ready) exp_q.push_back(cur_exp);
    end
  end

  initial begin
    //                op     pc          imm           val1          val2         rs1   rs2   rd    bv    brd   bdata
    tbl[0]  = mkv(8'h00, 32'h0,     32'h0,        32'hFFFF_FFFF, 32'h1,      5'd1, 5'd2, 5'd3, 1'b0, 5'd0, 32'h0,
                  mke(0, 1'b1, 32'h0, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0));
    tbl[1]  = mkv(8'h01, 32'h0,     32'h0,        32'h0,        32'h1,       5'd1, 5'd2, 5'd4, 1'b0, 5'd0, 32'h0,
                  mke(1, 1'b1, 32'hFFFF_FFFF, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0));
    tbl[2]  = mkv(8'h00, 32'h0,     32'h0,        32'h1,        32'h2,       5'd5, 5'd6, 5'd7, 1'b1, 5'd5, 32'd10,
                  mke(2, 1'b1, 32'd12, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0));
    tbl[3]  = mkv(8'h00, 32'h0,     32'h0,        32'h1,        32'h2,       5'd0, 5'd6, 5'd7, 1'b1, 5'd0, 32'd10,
                  mke(3, 1'b1, 32'd3, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0));
    tbl[4]  = mkv(8'h30, 32'h100,   32'hFFFF_FFF0, 32'd5,       32'd5,       5'd1, 5'd2, 5'd0, 1'b0, 5'd0, 32'h0,
                  mke(4, 1'b0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hF0, 1'b0));
    tbl[5]  = mkv(8'h30, 32'h100,   32'hFFFF_FFF0, 32'd5,       32'd6,       5'd1, 5'd2, 5'd0, 1'b0, 5'd0, 32'h0,
                  mke(5, 1'b0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0));
    tbl[6]  = mkv(8'h10, 32'h0,     32'h0,        32'h1000,     32'h20,      5'd1, 5'd2, 5'd9, 1'b0, 5'd0, 32'h0,
                  mke(6, 1'b1, 32'h1020, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0));
    tbl[7]  = mkv(8'h11, 32'h0,     32'h0,        32'h2000,     32'h4,       5'd1, 5'd2, 5'd9, 1'b0, 5'd0, 32'h0,
                  mke(7, 1'b1, 32'h2004, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0));
    tbl[8]  = mkv(8'h12, 32'h0,     32'h0,        32'h3000,     32'h1,       5'd1, 5'd2, 5'd0, 1'b0, 5'd0, 32'h0,
                  mke(8, 1'b1, 32'h3001, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0));
    tbl[9]  = mkv(8'h13, 32'h0,     32'h0,        32'h4000,     32'h8,       5'd1, 5'd2, 5'd0, 1'b0, 5'd0, 32'h0,
                  mke(9, 1'b1, 32'h4008, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0));
    tbl[10] = mkv(8'h31, 32'h50,    32'h0,        32'h400,      32'h0,       5'd1, 5'd2, 5'd0, 1'b0, 5'd0, 32'h0,
                  mke(10, 1'b0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h400, 1'b0));
    tbl[11] = mkv(8'h01, 32'h0,     32'h0,        32'd200,      32'd3,       5'd1, 5'd7, 5'd8, 1'b1, 5'd7, 32'd100,
                  mke(11, 1'b1, 32'd100, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0));
    tbl[12] = mkv(8'h00, 32'h0,     32'h0,        32'd1,        32'd1,       5'd4, 5'd2, 5'd6, 1'b0, 5'd4, 32'd50,
                  mke(12, 1'b1, 32'd2, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0));
    tbl[13] = mkv(8'h30, 32'h200,   32'h8,        32'd5,        32'd0,       5'd1, 5'd9, 5'd0, 1'b1, 5'd9, 32'd5,
                  mke(13, 1'b0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h208, 1'b0));
    tbl[14] = mkv(8'h03, 32'h0,     32'h0,        32'd1,        32'd1,       5'd1, 5'd2, 5'd3, 1'b0, 5'd0, 32'h0,
                  mke(14, 1'b0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1));

    // Reset state
    #2;
    chk("reset_valid", out_valid, 64'd0);
    chk("reset_result", out_result, 64'd0);
    chk("reset_flags", {out_rd, out_wr_en, out_mem_rd, out_mem_wr, out_branch_taken, out_illegal}, 64'd0);
    chk("reset_bpc", out_branch_pc, 64'd0);
    repeat (2) @(posedge clock);
    #1 reset_c = 1'b1;

    for (int i = 0; i < 15; i++) issue(tbl[i]);

    // MUL 7*6 via bypass on rs1; bypass changes after accept must not matter; stall from accept on
    v = mkv(8'h02, 32'h0, 32'h0, 32'd99, 32'd6, 5'd3, 5'd8, 5'd12, 1'b1, 5'd3, 32'd7,
            mke(100, 1'b1, 32'd42, 1'b1, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0));
    issue(v);
    byp_data = 32'd1000;
    stall_alu = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("mul_ready_low", in_ready, 64'd0);
      chk("mul_latency_valid", out_valid, (i >= 3) ? 64'd1 : 64'd0);
    end
    chk("mul_held_result", out_result, 64'd42);
    @(posedge clock);
    #1 stall_alu = 1'b0;
    byp_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk("mul_single_result", out_valid, 64'd0);
    @(posedge clock);
    #1;

    // Illegal opcode held by a 3-cycle stall
    v = mkv(8'h55, 32'h0, 32'h0, 32'd1, 32'd2, 5'd1, 5'd2, 5'd3, 1'b0, 5'd0, 32'h0,
            mke(200, 1'b0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1));
    issue(v);
    stall_alu = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("ill_valid", out_valid, 64'd1);
      chk("ill_flags", {out_illegal, out_wr_en, out_mem_rd, out_mem_wr, out_branch_taken}, 64'h10);
      chk("ill_ready_low", in_ready, 64'd0);
    end
    @(posedge clock);
    #1 stall_alu = 1'b0;
    @(negedge clock);
    @(posedge clock);
    #1;

    // Reset two cycles into a MUL: nothing may emerge afterwards
    v = mkv(8'h02, 32'h0, 32'h0, 32'd2, 32'd3, 5'd1, 5'd2, 5'd5, 1'b0, 5'd0, 32'h0,
            mke(300, 1'b1, 32'd6, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0));
    issue(v);
    @(posedge clock);
    #1 reset_c = 1'b0;
    exp_q.delete();
    #1;
    chk("midmul_reset_valid", out_valid, 64'd0);
    chk("midmul_reset_result", out_result, 64'd0);
    chk("midmul_reset_flags", {out_rd, out_wr_en, out_mem_rd, out_mem_wr, out_branch_taken, out_illegal}, 64'd0);
    chk("midmul_reset_ready", in_ready, 64'd1);
    @(posedge clock);
    #1 reset_c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("midmul_no_emit", out_valid, 64'd0);
    end
    @(posedge clock);
    #1;
    v = mkv(8'h00, 32'h0, 32'h0, 32'd3, 32'd4, 5'd1, 5'd2, 5'd6, 1'b0, 5'd0, 32'h0,
            mke(301, 1'b1, 32'd7, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0));
    issue(v);
    @(negedge clock);
    chk("post_reset_add_valid", out_valid, 64'd1);
    chk("post_reset_add_result", out_result, 64'd7);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clock);
    chk("queue_drained", exp_q.size(), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
